div_pipe_arbiter: RTL and testbench
===================================

Name: div_pipe_arbiter

Overview:
- Shares one fully pipelined restoring divider (fixed latency, no stall, one issue per cycle) among NREQ requesters.
- Each cycle it selects one requester round-robin and registers that requester's operands onto the divider inputs.
- It tracks each operation through the divider with a valid/ID/flag shift register and returns the result to the originating requester.
- It sits between the requester blocks and the divider instance; the divider's ports are connected externally.

Parameters:
- WIDTH, 4, divisor/remainder width; dividend and quotient are 2*WIDTH.
- NREQ, 2, number of requesters (>=2).
- LAT, 8, divider latency in clock edges from operand presentation to result; default equals 2*WIDTH.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester grant; combinational, one-hot or zero.
- req_dividend  input  NREQ*2*WIDTH  packed dividends; requester i uses slice i.
- req_divisor  input  NREQ*WIDTH  packed divisors.
- div_dividend  output  2*WIDTH  registered operand to divider.
- div_divisor  output  WIDTH  registered operand to divider.
- div_quotient  input  2*WIDTH  divider quotient.
- div_remainder  input  WIDTH  divider remainder.
- rsp_valid  output  NREQ  one-cycle result pulse to requester i.
- rsp_quotient  output  2*WIDTH  result quotient (shared bus).
- rsp_remainder  output  WIDTH  result remainder (shared bus).
- rsp_dbz  output  1  divide-by-zero flag for the current response.
- inflight  output  $clog2(LAT+2)  number of operations in flight.

Behaviour:
- Reset (async, rst_n=0) clears all outputs and state:
  - req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_dbz, div_dividend, div_divisor, inflight, shift register = 0.
  - RR pointer = 0.
- Arbitration (combinational, every cycle):
  - The highest-priority requester is the RR pointer, then pointer+1, ... wrapping mod NREQ.
  - req_ready[i]=1 only for the selected requester with req_valid=1; all zero if none is valid.
  - The block never backpressures otherwise: a request is accepted every cycle any req_valid is high.
- Accept at edge t (req_valid[g] & req_ready[g]):
  - div_dividend/div_divisor load slice g; they hold their value when nothing is accepted.
  - The shift-register stage 0 loads {valid=1, id=g, dbz=(divisor==0)}; otherwise stage 0 valid=0.
  - The RR pointer becomes (g+1) mod NREQ; it is unchanged with no grant.
- Tracking:
  - The shift register is LAT+1 stages deep and advances every cycle.
  - When the last stage is valid at an edge, the outputs register:
    - rsp_valid[id]=1;
    - rsp_quotient=div_quotient and rsp_remainder=div_remainder;
    - if dbz, rsp_quotient=all ones, rsp_remainder=0, rsp_dbz=1.
  - Otherwise rsp_valid=0, rsp_dbz=0, and data holds.
  - Latency: accept at edge t gives rsp_valid high in the cycle following edge t+LAT+1.
- Ordering and throughput:
  - Responses come back in acceptance order.
  - Back-to-back accepts give back-to-back responses.
  - Requesters must consume rsp_valid pulses unconditionally; there is no response backpressure.
- inflight:
  - +1 on accept, -1 on retire, unchanged when both happen in the same cycle.
  - Range 0..LAT+1; never wraps.
- Reset mid-operation: all in-flight operations are discarded, no rsp_valid after release, and the pointer returns to 0.

Optional Feature:
- Macro: DIV_PIPE_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the RR pointer is removed and is not updated.
- Undefined: round-robin as specified above.
- Latency and tracking are identical in both builds.

Test Plan:
- Single request, WIDTH=4, LAT=8: req0 dividend 100, divisor 7, accepted at edge t -> rsp_valid=2'b01 in cycle after edge t+9, quotient 14, remainder 2, rsp_dbz=0, inflight returns to 0.
- Both requesters holding req_valid for 6 cycles with distinct operands (req0 50/3, req1 200/9):
  - req_ready alternates 01,10,01,...;
  - responses arrive on consecutive cycles alternating rsp_valid 01,10;
  - req0 responses 16 r2, req1 responses 22 r2;
  - inflight peaks at 6.
- Divide by zero: req1 dividend 37, divisor 0 -> rsp_valid=2'b10, rsp_quotient=8'hFF, rsp_remainder=0, rsp_dbz=1.
- Reset mid-flight: 3 operations accepted, rst_n low 2 cycles after the third -> all outputs 0 immediately, no rsp_valid for LAT+2 cycles after release, next grant goes to req0.
- Simultaneous accept and retire on the same edge -> inflight unchanged. Continuous single-requester stream -> inflight saturates at LAT+1 = 9 and does not exceed it.
- With DIV_PIPE_ARB_FIXED_PRIO_EN: both requesters valid for 4 cycles -> req_ready=2'b01 every cycle and req1 is never granted until req0 deasserts.

Source files
------------

// File: rtl/div_pipe_arbiter.sv
// Round-robin front end sharing one fixed-latency pipelined divider among NREQ requesters.
// Define DIV_PIPE_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no RR pointer).
module div_pipe_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2,
    parameter int LAT   = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*2*WIDTH-1:0]     req_dividend,
    input  logic [NREQ*WIDTH-1:0]       req_divisor,
    output logic [2*WIDTH-1:0]          div_dividend,
    output logic [WIDTH-1:0]            div_divisor,
    input  logic [2*WIDTH-1:0]          div_quotient,
    input  logic [WIDTH-1:0]            div_remainder,
    output logic [NREQ-1:0]             rsp_valid,
    output logic [2*WIDTH-1:0]          rsp_quotient,
    output logic [WIDTH-1:0]            rsp_remainder,
    output logic                        rsp_dbz,
    output logic [$clog2(LAT+2)-1:0]    inflight
);
    localparam int DW   = 2 * WIDTH;
    localparam int PTRW = $clog2(NREQ);
    localparam int CW   = $clog2(LAT + 2);

    logic [NREQ-1:0]       w_grant;
    logic [PTRW-1:0]       w_gidx;
    logic                  w_acc;
    logic [DW-1:0]         w_sel_dvd;
    logic [WIDTH-1:0]      w_sel_dvs;
    logic                  w_ret;
    logic [NREQ-1:0]       w_rsp_hot;

    logic [DW-1:0]         r_div_dvd;
    logic [WIDTH-1:0]      r_div_dvs;
    logic [LAT:0]          r_sv;
    logic [LAT:0][PTRW-1:0] r_sid;
    logic [LAT:0]          r_sdbz;
    logic [NREQ-1:0]       r_rsp_valid;
    logic [DW-1:0]         r_rsp_q;
    logic [WIDTH-1:0]      r_rsp_r;
    logic                  r_rsp_dbz;
    logic [CW-1:0]         r_inflight;

`ifndef DIV_PIPE_ARB_FIXED_PRIO_EN
    logic [PTRW-1:0]       r_ptr;
`endif

    // Rotating priority as two ascending scans: indices at/after the pointer first, then the wrap.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_acc   = 1'b0;
`ifndef DIV_PIPE_ARB_FIXED_PRIO_EN
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (rst_n && !w_acc && req_valid[i] && (i >= 32'(r_ptr))) begin
                w_acc      = 1'b1;
                w_gidx     = PTRW'(i);
                w_grant[i] = 1'b1;
            end
        end
`endif
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (rst_n && !w_acc && req_valid[i]) begin
                w_acc      = 1'b1;
                w_gidx     = PTRW'(i);
                w_grant[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_dvd = '0;
        w_sel_dvs = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_dvd = req_dividend[i*DW +: DW];
                w_sel_dvs = req_divisor[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_ret = r_sv[LAT];

    always_comb begin
        w_rsp_hot = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_rsp_hot[i] = (r_sid[LAT] == PTRW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_dvd   <= '0;
            r_div_dvs   <= '0;
            r_sv        <= '0;
            r_sid       <= '0;
            r_sdbz      <= '0;
            r_rsp_valid <= '0;
            r_rsp_q     <= '0;
            r_rsp_r     <= '0;
            r_rsp_dbz   <= 1'b0;
            r_inflight  <= '0;
        end else begin
            if (w_acc) begin
                r_div_dvd <= w_sel_dvd;
                r_div_dvs <= w_sel_dvs;
            end
            r_sv   <= {r_sv[LAT-1:0], w_acc};
            r_sid  <= {r_sid[LAT-1:0], w_gidx};
            r_sdbz <= {r_sdbz[LAT-1:0], w_acc && (w_sel_dvs == '0)};
            if (w_ret) begin
                r_rsp_valid <= w_rsp_hot;
                if (r_sdbz[LAT]) begin
                    r_rsp_q   <= '1;
                    r_rsp_r   <= '0;
                    r_rsp_dbz <= 1'b1;
                end else begin
                    r_rsp_q   <= div_quotient;
                    r_rsp_r   <= div_remainder;
                    r_rsp_dbz <= 1'b0;
                end
            end else begin
                r_rsp_valid <= '0;
                r_rsp_dbz   <= 1'b0;
            end
            if (w_acc && !w_ret) begin
                r_inflight <= r_inflight + CW'(1);
            end else if (!w_acc && w_ret) begin
                r_inflight <= r_inflight - CW'(1);
            end
        end
    end

`ifndef DIV_PIPE_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_acc) begin
            r_ptr <= (w_gidx == PTRW'(NREQ - 1)) ? '0 : w_gidx + PTRW'(1);
        end
    end
`endif

    assign req_ready     = w_grant;
    assign div_dividend  = r_div_dvd;
    assign div_divisor   = r_div_dvs;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_quotient  = r_rsp_q;
    assign rsp_remainder = r_rsp_r;
    assign rsp_dbz       = r_rsp_dbz;
    assign inflight      = r_inflight;

endmodule

// File: tb/tb_div_pipe_arbiter.sv
// Scoreboard bench for div_pipe_arbiter with a behavioural LAT-stage divider on the div_* ports.
module tb_div_pipe_arbiter;
    localparam int WIDTH = 4;
    localparam int NREQ  = 2;
    localparam int LAT   = 8;
    localparam int DW    = 2 * WIDTH;
    localparam int CW    = $clog2(LAT + 2);

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NREQ-1:0]         req_valid = '0;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*DW-1:0]      req_dividend = '0;
    logic [NREQ*WIDTH-1:0]   req_divisor = '0;
    logic [DW-1:0]           div_dividend;
    logic [WIDTH-1:0]        div_divisor;
    logic [DW-1:0]           div_quotient;
    logic [WIDTH-1:0]        div_remainder;
    logic [NREQ-1:0]         rsp_valid;
    logic [DW-1:0]           rsp_quotient;
    logic [WIDTH-1:0]        rsp_remainder;
    logic                    rsp_dbz;
    logic [CW-1:0]           inflight;

    div_pipe_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient),
        .rsp_remainder(rsp_remainder), .rsp_dbz(rsp_dbz),
        .inflight(inflight)
    );

    always #5 clk = ~clk;

    // External divider: result appears LAT edges after operands are presented.
    // Divide-by-zero yields junk so the arbiter's override is observable.
    logic [DW+WIDTH-1:0] m_pipe [LAT];

    function automatic logic [DW+WIDTH-1:0] div_model(input logic [DW-1:0] a, input logic [WIDTH-1:0] b);
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        if (b == '0) return {8'hA5, 4'h5};
        q = a / DW'(b);
        r = a % DW'(b);
        return {q, r[WIDTH-1:0]};
    endfunction

    always @(posedge clk) begin
        m_pipe[0] <= div_model(div_dividend, div_divisor);
        for (int k = 1; k < LAT; k++) m_pipe[k] <= m_pipe[k-1];
    end
    assign div_quotient  = m_pipe[LAT-1][DW+WIDTH-1:WIDTH];
    assign div_remainder = m_pipe[LAT-1][WIDTH-1:0];

    typedef struct {
        int               id;
        logic [DW-1:0]    q;
        logic [WIDTH-1:0] r;
        logic             dbz;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   m_ptr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_grant(input logic [NREQ-1:0] v, input int ptr);
`ifdef DIV_PIPE_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
        for (int k = 0; k < NREQ; k++) if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
`endif
        return -1;
    endfunction

    task automatic check_rsp();
        exp_t e;
        if (rsp_valid !== '0) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
                chk("rsp_quotient", 32'(rsp_quotient), 32'(e.q));
                chk("rsp_remainder", 32'(rsp_remainder), 32'(e.r));
                chk("rsp_dbz", 32'(rsp_dbz), 32'(e.dbz));
                chk("rsp_latency", 32'(cyc), 32'(e.cyc + LAT + 1));
            end
        end else begin
            chk("rsp_dbz_idle", 32'(rsp_dbz), 32'd0);
            if (sb.size() > 0 && (sb[0].cyc + LAT + 1) <= cyc) begin
                e = sb.pop_front();
                chk("rsp_missing", 32'(rsp_valid), 32'(1) << e.id);
            end
        end
    endtask

    // One clock: check grant and record accepts before the edge, then check responses after it.
    task automatic step();
        int g;
        exp_t e;
        logic [DW-1:0] a;
        logic [WIDTH-1:0] b;
        logic [DW-1:0] rem;
        #1;
        g = (rst_n === 1'b1) ? exp_grant(req_valid, m_ptr) : -1;
        chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'(1) << g));
        if (g >= 0) begin
            a     = req_dividend[g*DW +: DW];
            b     = req_divisor[g*WIDTH +: WIDTH];
            e.id  = g;
            e.dbz = (b == '0);
            e.q   = e.dbz ? '1 : a / DW'(b);
            rem   = e.dbz ? '0 : a % DW'(b);
            e.r   = rem[WIDTH-1:0];
            e.cyc = cyc + 1;
            sb.push_back(e);
            m_ptr = (g + 1) % NREQ;
        end
        @(posedge clk);
        cyc++;
        #1;
        check_rsp();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_quotient"}, 32'(rsp_quotient), 32'd0);
        chk({tag, "_rsp_remainder"}, 32'(rsp_remainder), 32'd0);
        chk({tag, "_rsp_dbz"}, 32'(rsp_dbz), 32'd0);
        chk({tag, "_div_dividend"}, 32'(div_dividend), 32'd0);
        chk({tag, "_div_divisor"}, 32'(div_divisor), 32'd0);
        chk({tag, "_inflight"}, 32'(inflight), 32'd0);
    endtask

    initial begin
        // Reset state
        #2;
        check_all_zero("reset");
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single request: 100 / 7 = 14 r 2
        req_dividend[7:0] = 8'd100;
        req_divisor[3:0]  = 4'd7;
        req_valid = 2'b01;
        step();
        chk("single_div_dividend", 32'(div_dividend), 32'd100);
        chk("single_div_divisor", 32'(div_divisor), 32'd7);
        chk("single_inflight", 32'(inflight), 32'd1);
        req_valid = 2'b00;
        for (int i = 0; i < LAT + 3; i++) step();
        chk("single_inflight_drained", 32'(inflight), 32'd0);
        chk("hold_div_dividend", 32'(div_dividend), 32'd100);

        // Divide by zero on requester 1: 37 / 0
        req_dividend[15:8] = 8'd37;
        req_divisor[7:4]   = 4'd0;
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        for (int i = 0; i < LAT + 3; i++) step();

        // Both requesters for 6 cycles: 50/3 and 200/9
        req_dividend = {8'd200, 8'd50};
        req_divisor  = {4'd9, 4'd3};
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) step();
        chk("both_inflight_peak", 32'(inflight), 32'd6);
        req_valid = 2'b00;
        for (int i = 0; i < LAT + 3; i++) step();

        // Reset while three operations are in flight
        req_valid = 2'b11;
        for (int i = 0; i < 3; i++) step();
        req_valid = 2'b00;
        step();
        step();
        rst_n = 1'b0;
        sb.delete();
        m_ptr = 0;
        #1;
        check_all_zero("midreset");
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 2; i++) step();
        req_valid = 2'b11;
        step();
        req_valid = 2'b00;
        for (int i = 0; i < LAT + 3; i++) step();

        // Continuous stream on requester 0: inflight saturates at LAT+1
        req_valid = 2'b01;
        for (int k = 1; k <= LAT + 4; k++) begin
            req_dividend[7:0] = 8'(17 * k + 3);
            req_divisor[3:0]  = 4'(k % 15 + 1);
            step();
            chk("stream_inflight", 32'(inflight), 32'((k < LAT + 1) ? k : LAT + 1));
        end
        req_valid = 2'b00;
        for (int i = 0; i < LAT + 3; i++) step();
        chk("stream_inflight_drained", 32'(inflight), 32'd0);

        // Both valid for 4 cycles, then only requester 1
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) step();
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        for (int i = 0; i < LAT + 3; i++) step();

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
